// File: rtl/lock_pkg.sv
// Shared constants for the push-button front end and digital_lock.
// - Default debounce / auto-repeat timing.
// - Channel indices used to address per-channel vectors.
package lock_pkg;

  localparam int DEBOUNCE_DEFAULT      = 4;
  localparam int REPEAT_DELAY_DEFAULT  = 16;
  localparam int REPEAT_PERIOD_DEFAULT = 8;

  localparam int NUM_CH     = 5;
  localparam int CH_MOD3    = 0;
  localparam int CH_MOD10   = 1;
  localparam int CH_CONFIRM = 2;
  localparam int CH_ENTER   = 3;
  localparam int CH_MODE    = 4;

endpackage

// File: rtl/debounce_ch.sv
// One input channel:
// - two-flop synchroniser
// - debounce counter
// - registered rising-edge press pulse
// Ports:
//   clk     system clock, rising edge
//   rst_btn synchronous active-high reset
//   raw     asynchronous bouncy input
//   level   debounced level
//   press   one-cycle pulse on a debounced 0->1 change
module debounce_ch #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 20
) (
  input  logic clk,
  input  logic rst_btn,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             s1;
  logic             s2;
  logic             db;
  logic [CNT_W-1:0] cnt;
  logic             p;

  // Synchronise, then accept s2 only after it differs from db for a full window.
  always_ff @(posedge clk) begin
    if (rst_btn) begin
      s1  <= 1'b0;
      s2  <= 1'b0;
      db  <= 1'b0;
      cnt <= '0;
      p   <= 1'b0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      p  <= 1'b0;
      if (s2 == db) begin
        // Any sample agreeing with the accepted state restarts the window.
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        db  <= s2;
        cnt <= '0;
        p   <= s2;  // pulse on press only, release is silent
      end else begin
        cnt <= cnt + CNT_ONE;
      end
    end
  end

  assign level = db;
  assign press = p;

endmodule

// File: rtl/btn_conditioner.sv
// Push-button/switch conditioner in front of digital_lock.
// - Debounces five raw inputs.
// - Emits one-cycle press pulses for mod3/mod10/confirm/enter.
// - Passes a clean debounced level for mode.
// - mod10 auto-repeats while held (disabled when REPEAT_DELAY is 0).
// Ports:
//   clk, rst_btn            clock, synchronous active-high reset
//   *_raw                   asynchronous bouncy inputs
//   mod3_btn, mod10_btn,
//   confirm, enter          one-cycle press pulses
//   mode                    debounced switch level
module btn_conditioner
  import lock_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int REPEAT_DELAY    = REPEAT_DELAY_DEFAULT,
  parameter int REPEAT_PERIOD   = REPEAT_PERIOD_DEFAULT,
  parameter int CNT_W           = 20
) (
  input  logic clk,
  input  logic rst_btn,
  input  logic mod3_raw,
  input  logic mod10_raw,
  input  logic confirm_raw,
  input  logic enter_raw,
  input  logic mode_raw,
  output logic mod3_btn,
  output logic mod10_btn,
  output logic confirm,
  output logic enter,
  output logic mode
);

  logic [NUM_CH-1:0] raw_vec;
  logic [NUM_CH-1:0] level_vec;
  logic [NUM_CH-1:0] press_vec;
  logic              rep_pulse;

  assign raw_vec[CH_MOD3]    = mod3_raw;
  assign raw_vec[CH_MOD10]   = mod10_raw;
  assign raw_vec[CH_CONFIRM] = confirm_raw;
  assign raw_vec[CH_ENTER]   = enter_raw;
  assign raw_vec[CH_MODE]    = mode_raw;

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    debounce_ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_ch (
      .clk    (clk),
      .rst_btn(rst_btn),
      .raw    (raw_vec[ch]),
      .level  (level_vec[ch]),
      .press  (press_vec[ch])
    );
  end

  if (REPEAT_DELAY != 0) begin : g_rep
    localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);
    localparam logic [CNT_W-1:0] RC_ONE      = CNT_W'(1);

    logic [CNT_W-1:0] rc;
    logic [CNT_W-1:0] rc_next;
    logic             rep;
    logic             rep_next;
    logic             pulse;
    logic             pulse_next;

    // Repeat timing. rc sits at 0 while released, so the press cycle
    // starts counting from zero.
    always_comb begin
      rc_next    = rc;
      rep_next   = rep;
      pulse_next = 1'b0;
      if (!level_vec[CH_MOD10]) begin
        rc_next  = '0;
        rep_next = 1'b0;
      end else if (!rep && (rc == DELAY_LAST)) begin
        pulse_next = 1'b1;
        rep_next   = 1'b1;
        rc_next    = '0;
      end else if (rep && (rc == PERIOD_LAST)) begin
        pulse_next = 1'b1;
        rc_next    = '0;
      end else begin
        rc_next = rc + RC_ONE;
      end
    end

    // Repeat state register.
    always_ff @(posedge clk) begin
      if (rst_btn) begin
        rc    <= '0;
        rep   <= 1'b0;
        pulse <= 1'b0;
      end else begin
        rc    <= rc_next;
        rep   <= rep_next;
        pulse <= pulse_next;
      end
    end

    assign rep_pulse = pulse;
  end else begin : g_norep
    assign rep_pulse = 1'b0;
  end

  // Both terms are flop outputs and are never high together.
  assign mod3_btn  = press_vec[CH_MOD3];
  assign mod10_btn = press_vec[CH_MOD10] | rep_pulse;
  assign confirm   = press_vec[CH_CONFIRM];
  assign enter     = press_vec[CH_ENTER];
  assign mode      = level_vec[CH_MODE];

  // Levels of the pulse channels and the mode press are intentionally unused.
  logic unused_bits;
  assign unused_bits = ^{level_vec, press_vec[CH_MODE]};

endmodule

// File: tb/tb_btn_conditioner.sv
// Self-checking bench for btn_conditioner.
// - Stimulus tasks push expected pulses and mode changes (with the cycle
//   they must appear) into a scoreboard queue.
// - A monitor compares every cycle's outputs against the entries due then.
// - A second instance with REPEAT_DELAY=0 shares the inputs; its mod10
//   pulses are counted.
module tb_btn_conditioner;

  typedef struct {
    int         cyc;
    logic [3:0] pulse;   // {mod3, mod10, confirm, enter}
    logic       mode_upd;
    logic       mode_val;
  } exp_t;

  logic clk = 1'b0;
  logic rst_btn, mod3_raw, mod10_raw, confirm_raw, enter_raw, mode_raw;
  logic mod3_btn, mod10_btn, confirm, enter, mode;
  logic n_mod3, n_mod10, n_confirm, n_enter, n_mode;

  exp_t sb[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  int   norep_cnt = 0;
  logic exp_mode = 1'b0;

  always #5 clk = ~clk;

  btn_conditioner #(
    .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(16), .REPEAT_PERIOD(8), .CNT_W(20)
  ) dut (
    .clk(clk), .rst_btn(rst_btn), .mod3_raw(mod3_raw), .mod10_raw(mod10_raw),
    .confirm_raw(confirm_raw), .enter_raw(enter_raw), .mode_raw(mode_raw),
    .mod3_btn(mod3_btn), .mod10_btn(mod10_btn), .confirm(confirm),
    .enter(enter), .mode(mode)
  );

  btn_conditioner #(
    .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(0), .REPEAT_PERIOD(8), .CNT_W(20)
  ) dut_norep (
    .clk(clk), .rst_btn(rst_btn), .mod3_raw(mod3_raw), .mod10_raw(mod10_raw),
    .confirm_raw(confirm_raw), .enter_raw(enter_raw), .mode_raw(mode_raw),
    .mod3_btn(n_mod3), .mod10_btn(n_mod10), .confirm(n_confirm),
    .enter(n_enter), .mode(n_mode)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, want, cyc);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input int at, input logic [3:0] p, input logic mu, input logic mv);
    exp_t e;
    e.cyc = at; e.pulse = p; e.mode_upd = mu; e.mode_val = mv;
    sb.push_back(e);
  endtask

  // Monitor: sample 1 time unit after each rising edge.
  initial begin
    logic       rst_at_edge;
    logic [3:0] want;
    forever begin
      @(posedge clk);
      cyc++;
      rst_at_edge = rst_btn;
      #1;
      want = 4'b0000;
      if (rst_at_edge) exp_mode = 1'b0;
      for (int i = sb.size() - 1; i >= 0; i--) begin
        if (sb[i].cyc == cyc) begin
          want = want | sb[i].pulse;
          if (sb[i].mode_upd) exp_mode = sb[i].mode_val;
          sb.delete(i);
        end
      end
      check_eq("pulses", {28'd0, mod3_btn, mod10_btn, confirm, enter}, {28'd0, want});
      check_eq("mode", {31'd0, mode}, {31'd0, exp_mode});
      if (n_mod10) norep_cnt++;
    end
  end

  // Runaway guard.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    int base;
    rst_btn = 1'b1;
    mod3_raw = 1'b0; mod10_raw = 1'b0; confirm_raw = 1'b0;
    enter_raw = 1'b0; mode_raw = 1'b0;
    tick(3);
    rst_btn = 1'b0;
    tick(3);

    // Clean press on mod3: one pulse 6 edges after the driving negedge.
    n = cyc; mod3_raw = 1'b1; push(n + 6, 4'b1000, 1'b0, 1'b0);
    tick(20);
    mod3_raw = 1'b0;            // release: silent
    tick(12);

    // Bouncy enter: 1,0,1,1,0,1 then stable high.
    enter_raw = 1'b1; tick(1);
    enter_raw = 1'b0; tick(1);
    enter_raw = 1'b1; tick(1);
    tick(1);
    enter_raw = 1'b0; tick(1);
    n = cyc; enter_raw = 1'b1; push(n + 6, 4'b0001, 1'b0, 1'b0);
    tick(12);
    enter_raw = 1'b0;
    tick(12);

    // 3-cycle glitch on confirm: no pulse.
    confirm_raw = 1'b1; tick(3);
    confirm_raw = 1'b0; tick(12);

    // Auto-repeat on mod10: P, P+16, P+24, P+32, P+40, then release.
    base = norep_cnt;
    n = cyc; mod10_raw = 1'b1;
    push(n + 6, 4'b0100, 1'b0, 1'b0);
    push(n + 22, 4'b0100, 1'b0, 1'b0);
    push(n + 30, 4'b0100, 1'b0, 1'b0);
    push(n + 38, 4'b0100, 1'b0, 1'b0);
    push(n + 46, 4'b0100, 1'b0, 1'b0);
    tick(45);
    mod10_raw = 1'b0;           // db falls at n+51, before the n+54 repeat
    tick(20);
    check_eq("norep_single", norep_cnt - base, 32'd1);

    // Simultaneous mod3 + mod10 press and mode switch on.
    n = cyc; mod3_raw = 1'b1; mod10_raw = 1'b1; mode_raw = 1'b1;
    push(n + 6, 4'b1100, 1'b1, 1'b1);
    tick(8);
    mod3_raw = 1'b0; mod10_raw = 1'b0;
    tick(12);

    // Reset mid-debounce with mod3 and mode held: both restart from release.
    n = cyc; mod3_raw = 1'b1;
    tick(2);
    rst_btn = 1'b1;
    tick(2);
    n = cyc; rst_btn = 1'b0;
    push(n + 6, 4'b1000, 1'b1, 1'b1);
    tick(12);
    mod3_raw = 1'b0;
    n = cyc; mode_raw = 1'b0; push(n + 6, 4'b0000, 1'b1, 1'b0);
    tick(12);

    // Reset during auto-repeat: no repeats afterwards.
    n = cyc; mod10_raw = 1'b1;
    push(n + 6, 4'b0100, 1'b0, 1'b0);
    push(n + 22, 4'b0100, 1'b0, 1'b0);
    tick(25);
    rst_btn = 1'b1; mod10_raw = 1'b0;
    tick(3);
    rst_btn = 1'b0;
    tick(40);

    check_eq("sb_empty", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
